hex_keypad_reader: RTL
======================

# hex_keypad_reader

Scans a 4x4 matrix hex keypad, debounces key presses and assembles the last two accepted digits into the 8-bit value that the seven-segment display multiplexer shows. It is the input-side counterpart of the display multiplexer and sits between the keypad pins and the adder datapath and display. Column strobing is time-multiplexed in the same way as the display digits.

## Interface
- SCAN_TICKS, 50000: clk cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; minimum 1.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- row  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- clr  in  1  synchronous clear of value.
- col  out 4  column drive; one bit low at a time, active-low.
- key_code  out 4  hex code of the last accepted key.
- key_valid out 1  one-cycle strobe on each accepted press.
- key_held  out 1  high from acceptance until the release is accepted.
- value  out 8  {previous digit, last digit}; feeds the display controller.

## Operation
- Column scan: col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110. Each pattern is held SCAN_TICKS cycles.
- Row synchronisation: row passes through a 2-flop synchronizer. The synchronized row is sampled on the last dwell cycle of each column (tick == SCAN_TICKS-1).
- scan_done: an internal strobe raised on the column-3 sample.
- Scan result: one of none, single(code) or multi (more than one key down across the scan).
- Key map (row r top->bottom, col c left->right):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM advances only on scan_done. States:
  - IDLE: single(k) -> PRESS_CHK with cand=k, cnt=1; if DEBOUNCE_SCANS=1, accept immediately instead.
  - PRESS_CHK:
    - single(cand): cnt+1; accept when cnt reaches DEBOUNCE_SCANS.
    - single(other): cand=other, cnt=1.
    - none or multi: -> IDLE.
  - HELD:
    - none: -> REL_CHK, cnt=1 (release when DEBOUNCE_SCANS=1).
    - single/multi: stay.
  - REL_CHK:
    - none: cnt+1; release when cnt reaches DEBOUNCE_SCANS -> IDLE, key_held=0.
    - anything else: -> HELD.
- Accept action:
  - key_code=cand; key_valid=1 for one cycle; key_held=1; state HELD.
  - value={value[3:0], cand}.
- A held key never repeats. A second key pressed while one is held is ignored until a full release.
- clr: value=0 next cycle. Does not affect scanning, FSM, key_code or key_held.
- clr coincident with accept: value={4'h0, cand}.

## Timing
- Reset values:
  - col=1110; key_code=0; key_valid=0; key_held=0; value=00.
  - State IDLE; tick and cnt=0; synchronizer flops=1111.
- rst mid-operation: all of the above on the next edge. An in-progress debounce is discarded and scanning restarts at column 0.
- Latency: key_valid, key_code and value update on the cycle after the scan_done that completes the DEBOUNCE_SCANS-th consistent scan.
- A key must be stable through that column's sample point to register. Glitches between sample points are invisible.
- The tick counter wraps at SCAN_TICKS-1. The column index wraps 3 -> 0 with no idle gap.

## Structure
- Package hex_keypad_pkg holds:
  - the state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - the 16-entry row/col -> code map as a constant function;
  - the scan-result type (none/single/multi + code).
- One sub-module, keypad_col_scan, owns:
  - the tick counter and column drive;
  - the row synchronizer and per-scan result assembly;
  - the scan_done strobe.
- Top level owns the debounce FSM and the value register.

## Test plan
All scenarios use SCAN_TICKS=4 and DEBOUNCE_SCANS=2 (full scan = 16 cycles).
- Reset, then idle 100 cycles:
  - col rotates 1110, 1101, 1011, 0111 every 4 cycles;
  - key_valid never asserts; value=00.
- Hold r1c2 ("6") for 3 full scans:
  - exactly one key_valid, one cycle after the 2nd scan_done;
  - key_code=6; value=06; key_held=1.
- Then release "6" for 2 scans:
  - key_held falls one cycle after the 2nd empty scan_done.
- Press "A" (r0c3), release, press "3" (r0c2), release:
  - value sequence 0A then A3;
  - a further press "0" (r3c0) gives value=30.
- Bounce r2c1 ("8") present for 1 scan, absent 1, present 1, then stable:
  - no accept until 2 consecutive scans;
  - then one strobe, key_code=8.
- Other edge cases:
  - Hold "1" and "2" together: no accept.
  - clr asserted with an accept of "F": value=0F.
  - rst mid-PRESS_CHK: no strobe, all outputs at reset values.

Source files
------------

// File: rtl/hex_keypad_pkg.sv
// Shared types for the hex keypad reader: debounce states, scan result and key map.
package hex_keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_kind_t;

    typedef struct packed {
        scan_kind_t kind;
        logic [3:0] code;
    } scan_res_t;

    // Row r (top->bottom), column c (left->right) to hex code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hex_keypad_reader_if.sv
// Keypad pins plus the decoded-key and display-value bus of the keypad reader.
interface hex_keypad_reader_if;
    logic [3:0] row;
    logic       clr;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] value;

    modport master (
        input  row, clr,
        output col, key_code, key_valid, key_held, value
    );

    modport slave (
        output row, clr,
        input  col, key_code, key_valid, key_held, value
    );
endinterface

// File: rtl/keypad_col_scan.sv
// Column strobe generator, row synchronizer and per-scan result assembly.
module keypad_col_scan
    import hex_keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS = 50000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic      scan_done_o,
    output scan_res_t scan_res_o
);

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

    logic [TW-1:0] tick_q;
    logic [3:0]    col_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    seen_q;      // keys seen so far this scan, saturating at 2
    logic [3:0]    code_q;
    logic          scan_done_q;
    scan_res_t     scan_res_q;

    logic [3:0] hits;
    logic [2:0] nhit;
    logic [1:0] row_idx;
    logic [2:0] sum;
    logic [1:0] seen_d;
    logic [3:0] code_d;
    scan_res_t  res_d;

    // Fold the current column's synchronized rows into the running scan tally.
    always_comb begin
        hits    = ~sync2_q;
        nhit    = '0;
        row_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (hits[i]) begin
                nhit    = nhit + 3'd1;
                row_idx = 2'(i);
            end
        end
        sum    = {1'b0, seen_q} + nhit;
        seen_d = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_d = (seen_q == 2'd0 && nhit == 3'd1) ? key_map(row_idx, col_idx_q) : code_q;
        res_d  = '{kind: SCAN_NONE, code: code_d};
        if (seen_d == 2'd1) begin
            res_d.kind = SCAN_SINGLE;
        end else if (seen_d == 2'd2) begin
            res_d.kind = SCAN_MULTI;
        end
    end

    // Dwell counter, column rotation, synchronizer and end-of-scan publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q      <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            seen_q      <= '0;
            code_q      <= '0;
            scan_done_q <= 1'b0;
            scan_res_q  <= '{kind: SCAN_NONE, code: 4'h0};
        end else begin
            sync1_q     <= row_i;
            sync2_q     <= sync1_q;
            scan_done_q <= 1'b0;
            if (tick_q == TICK_LAST) begin
                tick_q    <= '0;
                col_q     <= {col_q[2:0], col_q[3]};
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    scan_done_q <= 1'b1;
                    scan_res_q  <= res_d;
                    seen_q      <= '0;
                    code_q      <= '0;
                end else begin
                    seen_q <= seen_d;
                    code_q <= code_d;
                end
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    assign col_o       = col_q;
    assign scan_done_o = scan_done_q;
    assign scan_res_o  = scan_res_q;

endmodule

// File: rtl/hex_keypad_reader.sv
// 4x4 hex keypad reader: scan, debounce press/release, shift accepted digits into value.
module hex_keypad_reader
    import hex_keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic             clk,
    input logic             rst,
    hex_keypad_reader_if.master kp
);

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic      scan_done;
    scan_res_t scan_res;

    state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0] cand_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;
    logic [7:0] value_q;

    logic is_none, is_single, cnt_last, accept, rel_now;

    keypad_col_scan #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .row_i       (kp.row),
        .col_o       (kp.col),
        .scan_done_o (scan_done),
        .scan_res_o  (scan_res)
    );

    // Decide whether this scan completes a press or a release.
    always_comb begin
        is_none   = (scan_res.kind == SCAN_NONE);
        is_single = (scan_res.kind == SCAN_SINGLE);
        cnt_last  = (cnt_q == CNT_LAST);
        accept    = 1'b0;
        rel_now   = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE:      accept  = is_single && (DEBOUNCE_SCANS == 1);
                PRESS_CHK: accept  = is_single && (scan_res.code == cand_q) && cnt_last;
                HELD:      rel_now = is_none && (DEBOUNCE_SCANS == 1);
                REL_CHK:   rel_now = is_none && cnt_last;
                default:   ;
            endcase
        end
    end

    // Debounce FSM with registered key outputs and the display value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            value_q     <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= scan_res.code;
                key_held_q <= 1'b1;
                value_q    <= kp.clr ? {4'h0, scan_res.code} : {value_q[3:0], scan_res.code};
            end else if (kp.clr) begin
                value_q <= '0;
            end
            if (rel_now) begin
                key_held_q <= 1'b0;
            end
            if (scan_done) begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (is_single) begin
                            state_q <= PRESS_CHK;
                            cand_q  <= scan_res.code;
                            cnt_q   <= CW'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (accept) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (is_single) begin
                            if (scan_res.code == cand_q) begin
                                cnt_q <= cnt_q + CW'(1);
                            end else begin
                                cand_q <= scan_res.code;
                                cnt_q  <= CW'(1);
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    HELD: begin
                        if (is_none) begin
                            if (rel_now) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= REL_CHK;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    REL_CHK: begin
                        if (is_none) begin
                            if (rel_now) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.value     = value_q;

endmodule
